controle_principal: RTL and testbench

- Multicycle main control FSM for the MIPS-subset datapath.
- Drives the 2-bit ALU-op code consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode from opcode/funct, 11 = no-op.
- Also sequences PC, IR, memory, register-file and mux selects across fetch/decode/execute/memory/writeback.
- Handles a parameterised memory latency and invalid-opcode traps.

---
 rtl/controle_principal.sv | 262 ++++++++++++++++++++++++++
 tb/tb_controle_principal.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_principal.sv
// controle_principal: multicycle main control FSM for the MIPS-subset datapath.
// Moore outputs are decoded from the registered state. Memory reads (FETCH and
// MEM_READ) are stretched to MEM_WAIT+1 cycles by a 3-bit wait counter.
// Optional feature macro: OVERFLOW_TRAP_EN (routes add/sub/addi overflow to OVF).
//
// state        | code | meaning
// -------------+------+-------------------------------------------------------
// S_RST        |  0   | held in reset, all outputs low
// S_FETCH      |  1   | instruction read; IR/PC load on the last wait cycle
// S_DECODE     |  2   | branch target into ALUOut, dispatch on opcode
// S_MEM_ADDR   |  3   | effective address for lw/sw
// S_MEM_READ   |  4   | data read, MEM_WAIT+1 cycles
// S_MEM_WB     |  5   | MDR -> rt
// S_MEM_WRITE  |  6   | single-cycle store
// S_R_EXEC     |  7   | R-type ALU operation
// S_R_WB       |  8   | ALUOut -> rd
// S_I_EXEC     |  9   | I-type ALU operation
// S_I_WB       | 10   | ALUOut -> rt
// S_BRANCH     | 11   | beq/bne compare and conditional PC write
// S_JUMP       | 12   | PC <- jump target
// S_TRAP       | 13   | invalid opcode exception
// S_OVF        | 14   | arithmetic overflow exception
// S_UNUSED     | 15   | unreachable, recovers to FETCH

module controle_principal #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       epc_write,
  output logic       exc_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13,
    S_OVF       = 4'd14,
    S_UNUSED    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] wait_cnt;
  logic       wait_done;
  logic       r_ovf;
  logic       i_ovf;

  assign wait_done = (wait_cnt == WAIT_LAST);
  assign state     = state_q;

`ifdef OVERFLOW_TRAP_EN
  // only signed add/sub/addi can fault; unsigned variants never trap
  assign r_ovf = overflow && ((funct == 6'h20) || (funct == 6'h22));
  assign i_ovf = overflow && (opcode == OP_ADDI);
`else
  logic unused_ovf_in;
  assign unused_ovf_in = overflow ^ (^funct);
  assign r_ovf = 1'b0;
  assign i_ovf = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // wait counter: restarts on every state change, counts while a read is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 3'd0;
    end else if ((state_d == state_q) &&
                 ((state_q == S_FETCH) || (state_q == S_MEM_READ))) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= 3'd0;
    end
  end

  // next-state and Moore output decode
  always_comb begin
    state_d       = state_q;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    exc_cause     = 1'b0;

    unique case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (wait_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_RTYPE:                                      state_d = S_R_EXEC;
          OP_LW, OP_SW:                                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                                state_d = S_BRANCH;
          OP_J:                                          state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_XORI:  state_d = S_I_EXEC;
          default:                                       state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (wait_done) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = S_FETCH;
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = r_ovf ? S_OVF : S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = i_ovf ? S_OVF : S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = (opcode == OP_BNE);
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        epc_write = 1'b1;
        pc_source = 2'b11;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      S_OVF: begin
        epc_write = 1'b1;
        pc_source = 2'b11;
        pc_write  = 1'b1;
`ifdef OVERFLOW_TRAP_EN
        exc_cause = 1'b1;
`endif
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_principal.sv
// Directed bench for controle_principal: one instance with MEM_WAIT=1 for most
// instruction classes and a reset mid-read, one with MEM_WAIT=2 for lw timing.
module tb_controle_principal;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // output vector field masks:
  // {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
  //  branch_ne, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, epc_write, exc_cause}
  localparam logic [18:0] EXC        = 19'(1) << 0;
  localparam logic [18:0] EPCW       = 19'(1) << 1;
  localparam logic [18:0] REGW       = 19'(1) << 2;
  localparam logic [18:0] M2R        = 19'(1) << 3;
  localparam logic [18:0] RDST       = 19'(1) << 4;
  localparam logic [18:0] IRW        = 19'(1) << 5;
  localparam logic [18:0] MEMW       = 19'(1) << 6;
  localparam logic [18:0] MEMR       = 19'(1) << 7;
  localparam logic [18:0] IORD       = 19'(1) << 8;
  localparam logic [18:0] BNE        = 19'(1) << 9;
  localparam logic [18:0] PWC        = 19'(1) << 10;
  localparam logic [18:0] PCW        = 19'(1) << 11;
  localparam logic [18:0] PCS_ALUOUT = 19'(1) << 12;
  localparam logic [18:0] PCS_JUMP   = 19'(2) << 12;
  localparam logic [18:0] PCS_EXC    = 19'(3) << 12;
  localparam logic [18:0] SRCB_4     = 19'(1) << 14;
  localparam logic [18:0] SRCB_IMM   = 19'(2) << 14;
  localparam logic [18:0] SRCB_IMM2  = 19'(3) << 14;
  localparam logic [18:0] SRCA_REG   = 19'(1) << 16;
  localparam logic [18:0] OP_SUB     = 19'(1) << 17;
  localparam logic [18:0] OP_FUNC    = 19'(2) << 17;

  localparam logic [18:0] E_FETCH    = MEMR | SRCB_4;
  localparam logic [18:0] E_FETCH_L  = MEMR | SRCB_4 | IRW | PCW;
  localparam logic [18:0] E_DECODE   = SRCB_IMM2;
  localparam logic [18:0] E_MADDR    = SRCA_REG | SRCB_IMM;
  localparam logic [18:0] E_MREAD    = MEMR | IORD;
  localparam logic [18:0] E_MWB      = REGW | M2R;
  localparam logic [18:0] E_MWRITE   = MEMW | IORD;
  localparam logic [18:0] E_REXEC    = SRCA_REG | OP_FUNC;
  localparam logic [18:0] E_RWB      = REGW | RDST;
  localparam logic [18:0] E_IEXEC    = SRCA_REG | SRCB_IMM | OP_FUNC;
  localparam logic [18:0] E_IWB      = REGW;
  localparam logic [18:0] E_BEQ      = SRCA_REG | OP_SUB | PCS_ALUOUT | PWC;
  localparam logic [18:0] E_BNE      = E_BEQ | BNE;
  localparam logic [18:0] E_JUMP     = PCS_JUMP | PCW;
  localparam logic [18:0] E_TRAP     = EPCW | PCS_EXC | PCW;
  localparam logic [18:0] E_OVF      = EPCW | EXC | PCS_EXC | PCW;

  // instance 1: MEM_WAIT = 1
  logic       reset_n = 1'b0;
  logic [5:0] opcode  = 6'h00;
  logic [5:0] funct   = 6'h20;
  logic       overflow = 1'b0;
  logic [1:0] alu_op1, alu_src_b1, pc_source1;
  logic       alu_src_a1, pc_write1, pc_write_cond1, branch_ne1, i_or_d1;
  logic       mem_read1, mem_write1, ir_write1, reg_dst1, mem_to_reg1;
  logic       reg_write1, epc_write1, exc_cause1;
  logic [3:0] state1;
  logic [18:0] o1;

  // instance 2: MEM_WAIT = 2
  logic       reset2_n = 1'b0;
  logic [5:0] opcode2  = 6'h23;
  logic [1:0] alu_op2, alu_src_b2, pc_source2;
  logic       alu_src_a2, pc_write2, pc_write_cond2, branch_ne2, i_or_d2;
  logic       mem_read2, mem_write2, ir_write2, reg_dst2, mem_to_reg2;
  logic       reg_write2, epc_write2, exc_cause2;
  logic [3:0] state2;
  logic [18:0] o2;

  controle_principal #(.MEM_WAIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .overflow(overflow), .alu_op(alu_op1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .pc_source(pc_source1), .pc_write(pc_write1),
    .pc_write_cond(pc_write_cond1), .branch_ne(branch_ne1), .i_or_d(i_or_d1),
    .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
    .epc_write(epc_write1), .exc_cause(exc_cause1), .state(state1)
  );

  controle_principal #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .reset_n(reset2_n), .opcode(opcode2), .funct(funct),
    .overflow(overflow), .alu_op(alu_op2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .pc_source(pc_source2), .pc_write(pc_write2),
    .pc_write_cond(pc_write_cond2), .branch_ne(branch_ne2), .i_or_d(i_or_d2),
    .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .reg_write(reg_write2),
    .epc_write(epc_write2), .exc_cause(exc_cause2), .state(state2)
  );

  assign o1 = {alu_op1, alu_src_a1, alu_src_b1, pc_source1, pc_write1,
               pc_write_cond1, branch_ne1, i_or_d1, mem_read1, mem_write1,
               ir_write1, reg_dst1, mem_to_reg1, reg_write1, epc_write1,
               exc_cause1};
  assign o2 = {alu_op2, alu_src_a2, alu_src_b2, pc_source2, pc_write2,
               pc_write_cond2, branch_ne2, i_or_d2, mem_read2, mem_write2,
               ir_write2, reg_dst2, mem_to_reg2, reg_write2, epc_write2,
               exc_cause2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1(input string tag, input logic [3:0] es, input logic [18:0] eo);
    @(negedge clk);
    chk({tag, "/state"}, 32'(state1), 32'(es));
    chk({tag, "/outs"}, 32'(o1), 32'(eo));
  endtask

  task automatic cyc2(input string tag, input logic [3:0] es, input logic [18:0] eo);
    @(negedge clk);
    chk({tag, "/state"}, 32'(state2), 32'(es));
    chk({tag, "/outs"}, 32'(o2), 32'(eo));
  endtask

  // exclusivity of strobes on both instances, every cycle
  always @(negedge clk) begin
    chk("excl1", {30'd0, mem_read1 & mem_write1, reg_write1 & pc_write1}, 32'd0);
    chk("excl2", {30'd0, mem_read2 & mem_write2, reg_write2 & pc_write2}, 32'd0);
  end

  initial begin
    // reset held for 3 cycles
    cyc1("rst_a", 4'd0, 19'd0);
    cyc1("rst_b", 4'd0, 19'd0);
    cyc1("rst_c", 4'd0, 19'd0);
    reset_n = 1'b1;

    // R-type add
    cyc1("add_f0", 4'd1, E_FETCH);
    cyc1("add_f1", 4'd1, E_FETCH_L);
    cyc1("add_dec", 4'd2, E_DECODE);
    cyc1("add_ex", 4'd7, E_REXEC);
    cyc1("add_wb", 4'd8, E_RWB);
    opcode = 6'h05;

    // bne
    cyc1("bne_f0", 4'd1, E_FETCH);
    cyc1("bne_f1", 4'd1, E_FETCH_L);
    cyc1("bne_dec", 4'd2, E_DECODE);
    cyc1("bne_br", 4'd11, E_BNE);
    opcode = 6'h04;

    // beq
    cyc1("beq_f0", 4'd1, E_FETCH);
    cyc1("beq_f1", 4'd1, E_FETCH_L);
    cyc1("beq_dec", 4'd2, E_DECODE);
    cyc1("beq_br", 4'd11, E_BEQ);
    opcode = 6'h2B;

    // sw
    cyc1("sw_f0", 4'd1, E_FETCH);
    cyc1("sw_f1", 4'd1, E_FETCH_L);
    cyc1("sw_dec", 4'd2, E_DECODE);
    cyc1("sw_addr", 4'd3, E_MADDR);
    cyc1("sw_wr", 4'd6, E_MWRITE);
    opcode = 6'h02;

    // j
    cyc1("j_f0", 4'd1, E_FETCH);
    cyc1("j_f1", 4'd1, E_FETCH_L);
    cyc1("j_dec", 4'd2, E_DECODE);
    cyc1("j_jmp", 4'd12, E_JUMP);
    opcode = 6'h3F;

    // invalid opcode
    cyc1("trap_f0", 4'd1, E_FETCH);
    cyc1("trap_f1", 4'd1, E_FETCH_L);
    cyc1("trap_dec", 4'd2, E_DECODE);
    cyc1("trap", 4'd13, E_TRAP);
    opcode = 6'h08;
    overflow = 1'b1;

    // addi with overflow
    cyc1("addi_f0", 4'd1, E_FETCH);
    cyc1("addi_f1", 4'd1, E_FETCH_L);
    cyc1("addi_dec", 4'd2, E_DECODE);
    cyc1("addi_ex", 4'd9, E_IEXEC);
`ifdef OVERFLOW_TRAP_EN
    cyc1("addi_ovf", 4'd14, E_OVF);
`else
    cyc1("addi_wb", 4'd10, E_IWB);
`endif
    overflow = 1'b0;
    opcode = 6'h23;

    // lw, MEM_WAIT=1: 5 + 2 = 7 cycles
    cyc1("lw_f0", 4'd1, E_FETCH);
    cyc1("lw_f1", 4'd1, E_FETCH_L);
    cyc1("lw_dec", 4'd2, E_DECODE);
    cyc1("lw_addr", 4'd3, E_MADDR);
    cyc1("lw_rd0", 4'd4, E_MREAD);
    cyc1("lw_rd1", 4'd4, E_MREAD);
    cyc1("lw_wb", 4'd5, E_MWB);

    // lw again, reset asserted during the second MEM_READ cycle
    cyc1("lwr_f0", 4'd1, E_FETCH);
    cyc1("lwr_f1", 4'd1, E_FETCH_L);
    cyc1("lwr_dec", 4'd2, E_DECODE);
    cyc1("lwr_addr", 4'd3, E_MADDR);
    cyc1("lwr_rd0", 4'd4, E_MREAD);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst/state", 32'(state1), 32'd0);
    chk("midrst/outs", 32'(o1), 32'd0);
    cyc1("midrst_hold", 4'd0, 19'd0);
    reset_n = 1'b1;
    cyc1("rel_f0", 4'd1, E_FETCH);
    cyc1("rel_f1", 4'd1, E_FETCH_L);
    cyc1("rel_dec", 4'd2, E_DECODE);

    // instance 2: lw with MEM_WAIT=2, 9 cycles FETCH to FETCH
    cyc2("w2_rst", 4'd0, 19'd0);
    reset2_n = 1'b1;
    cyc2("w2_f0", 4'd1, E_FETCH);
    cyc2("w2_f1", 4'd1, E_FETCH);
    cyc2("w2_f2", 4'd1, E_FETCH_L);
    cyc2("w2_dec", 4'd2, E_DECODE);
    cyc2("w2_addr", 4'd3, E_MADDR);
    cyc2("w2_rd0", 4'd4, E_MREAD);
    cyc2("w2_rd1", 4'd4, E_MREAD);
    cyc2("w2_rd2", 4'd4, E_MREAD);
    cyc2("w2_wb", 4'd5, E_MWB);
    cyc2("w2_next", 4'd1, E_FETCH);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
